// File: rtl/alu_pwr_sched.sv
// Shared-ALU scheduler: round-robin arbitration of NUM_REQ requesters onto one
// multi-cycle ALU, with on-demand power-up and idle-timeout power-down sequencing.
module alu_pwr_sched #(
    parameter int NUM_REQ      = 2,
    parameter int PWR_UP_CYC   = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0]  req_op,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_id,
    output logic [15:0]           rsp_data,
    output logic                  alu_pwr_en,
    output logic                  alu_iso_en,
    output logic                  alu_start,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [3:0]            alu_op,
    input  logic                  alu_busy,
    input  logic [15:0]           alu_result,
    output logic [2:0]            pwr_state
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWR_UP = 3'd1,
        S_READY  = 3'd2,
        S_ISO_ON = 3'd3,
        S_ISSUE  = 3'd4,
        S_WAIT   = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    // One counter serves both the power-up delay and the idle timeout.
    localparam int CNT_MAX = (PWR_UP_CYC > IDLE_TIMEOUT) ? PWR_UP_CYC : IDLE_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       winner;
    logic             grant_any;
    logic [15:0]      sel_a, sel_b;
    logic [3:0]       sel_op;

    // Round-robin search starting at ptr, then payload mux for the winner.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant_any = 1'b0;
        winner    = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && req_valid[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
                    grant_any = 1'b1;
                    winner    = 2'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 2'(i)) begin
                sel_a  = req_a[16*i +: 16];
                sel_b  = req_b[16*i +: 16];
                sel_op = req_op[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        unique case (state)
            S_OFF: begin
                if (|req_valid) begin
                    state_nxt = S_PWR_UP;
                    cnt_nxt   = '0;
                end
            end
            S_PWR_UP: begin
                if (cnt == CNT_W'(PWR_UP_CYC - 1)) begin
                    state_nxt = S_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_READY: begin
                if (grant_any) begin
                    state_nxt = S_ISSUE;
                    cnt_nxt   = '0;
                    ptr_nxt   = (winner == 2'(NUM_REQ - 1)) ? 2'd0 : winner + 2'd1;
                end else if (cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
                    state_nxt = S_ISO_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ISO_ON: state_nxt = S_OFF;
            S_ISSUE:  state_nxt = S_WAIT;
            S_WAIT:   if (!alu_busy) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_READY;
            default:  state_nxt = S_OFF;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == S_READY) && grant_any && (winner == 2'(i));
        end
    end

    assign alu_pwr_en = (state != S_OFF);
    assign alu_iso_en = (state == S_OFF) || (state == S_PWR_UP) || (state == S_ISO_ON);
    assign alu_start  = (state == S_ISSUE);
    assign rsp_valid  = (state == S_RESP);
    assign pwr_state  = state;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= S_OFF;
            cnt      <= '0;
            ptr      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            // Operands stay latched through ISSUE/WAIT so the ALU sees stable inputs.
            if (state == S_READY && grant_any) begin
                alu_a  <= sel_a;
                alu_b  <= sel_b;
                alu_op <= sel_op;
                rsp_id <= winner;
            end
            if (state == S_WAIT && !alu_busy) begin
                rsp_data <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_pwr_sched.sv
// Bench for alu_pwr_sched: a bench-side ALU, a transaction-level model of grants,
// latency and power sequencing checked every cycle, and directed hand-computed cases.
module tb_alu_pwr_sched;

    localparam int NUM_REQ      = 2;
    localparam int PWR_UP_CYC   = 4;
    localparam int IDLE_TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0]  req_op;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [15:0]           rsp_data;
    logic                  alu_pwr_en;
    logic                  alu_iso_en;
    logic                  alu_start;
    logic [15:0]           alu_a;
    logic [15:0]           alu_b;
    logic [3:0]            alu_op;
    logic                  alu_busy;
    logic [15:0]           alu_result;
    logic [2:0]            pwr_state;

    alu_pwr_sched #(
        .NUM_REQ(NUM_REQ), .PWR_UP_CYC(PWR_UP_CYC), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_pwr_en(alu_pwr_en), .alu_iso_en(alu_iso_en), .alu_start(alu_start),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_busy(alu_busy), .alu_result(alu_result),
        .pwr_state(pwr_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd8:    return 16'(a * b);
            4'd9:    return (b == 16'd0) ? 16'd0 : a / b;
            default: return 16'd0;
        endcase
    endfunction

    function automatic int busy_len(input logic [3:0] op);
        if (op == 4'd8) return 5;
        if (op == 4'd9) return 9;
        return 0;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Bench-side ALU: result is combinational, busy is raised for the op's length
    // starting in the cycle after alu_start.
    assign alu_result = alu_ref(alu_a, alu_b, alu_op);
    int busy_rem = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_rem = 0;
            alu_busy = 1'b0;
        end else if (alu_start) begin
            busy_rem = busy_len(alu_op);
            alu_busy = 1'b0;
        end else if (busy_rem > 0) begin
            alu_busy = 1'b1;
            busy_rem--;
        end else begin
            alu_busy = 1'b0;
        end
    end

    // Transaction-level reference model and per-cycle comparison.
    bit          txn_active = 1'b0;
    int          acc_cyc, due_cyc, exp_id, ptr_m = 0;
    logic [15:0] exp_data, sav_a, sav_b;
    logic [3:0]  sav_op;
    int          idle_run = 0, up_run = 0, last_rsp_cyc = 0;
    bit          prev_rst = 1'b1, prev_pwr = 1'b0, prev_iso = 1'b1, prev2_iso = 1'b1;
    bit          prev_any_valid = 1'b0;
    int          grant_log[$];
    int          rsp_log[$];

    always @(negedge clk) begin
        if (mon_en) begin : mon
            bit                 act_before, ready_c, idle_c, exp_rsp;
            int                 w;
            logic [NUM_REQ-1:0] exp_ready;
            act_before = txn_active;
            idle_c     = 1'b0;
            if (prev_rst) begin
                check("reset_pwr_en", alu_pwr_en, 1'b0);
                check("reset_iso_en", alu_iso_en, 1'b1);
                check("reset_start", alu_start, 1'b0);
                check("reset_rsp_valid", rsp_valid, 1'b0);
                check("reset_req_ready", req_ready, '0);
                check("reset_rsp_data", rsp_data, 16'd0);
                check("reset_alu_a", alu_a, 16'd0);
            end else begin
                if (!prev_pwr)                   check("pwr_en_on_demand", alu_pwr_en, prev_any_valid);
                else if (prev_iso && !prev2_iso) check("pwr_off_after_iso", alu_pwr_en, 1'b0);
                else                             check("pwr_en_held", alu_pwr_en, 1'b1);

                if (!alu_pwr_en)                 check("iso_while_off", alu_iso_en, 1'b1);
                else if (prev_pwr && !prev_iso)  check("iso_idle_timeout", alu_iso_en, idle_run == IDLE_TIMEOUT);
                else                             check("iso_power_up", alu_iso_en, up_run < PWR_UP_CYC);

                ready_c   = alu_pwr_en && !alu_iso_en && !act_before;
                exp_ready = '0;
                w         = ready_c ? rr_pick(req_valid, ptr_m) : -1;
                if (w >= 0) exp_ready[w] = 1'b1;
                check("req_ready_grant", req_ready, exp_ready);
                check("alu_start", alu_start, act_before && (cyc == acc_cyc + 1));

                if (act_before && cyc > acc_cyc) begin
                    check("hold_alu_a", alu_a, sav_a);
                    check("hold_alu_b", alu_b, sav_b);
                    check("hold_alu_op", alu_op, sav_op);
                end

                exp_rsp = act_before && (cyc == due_cyc);
                check("rsp_valid", rsp_valid, exp_rsp);
                if (exp_rsp) begin
                    check("rsp_data", rsp_data, exp_data);
                    check("rsp_id", rsp_id, exp_id);
                    txn_active   = 1'b0;
                    last_rsp_cyc = cyc;
                end

                if (w >= 0 && !rst) begin
                    txn_active = 1'b1;
                    acc_cyc    = cyc;
                    exp_id     = w;
                    sav_a      = req_a[16*w +: 16];
                    sav_b      = req_b[16*w +: 16];
                    sav_op     = req_op[4*w +: 4];
                    exp_data   = alu_ref(sav_a, sav_b, sav_op);
                    due_cyc    = cyc + 3 + busy_len(sav_op);
                    ptr_m      = (w + 1) % NUM_REQ;
                end
                idle_c = ready_c && !(|req_valid);
            end

            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grant_log.push_back(i);
            if (rsp_valid) rsp_log.push_back(int'(rsp_id));

            idle_run       = idle_c ? idle_run + 1 : 0;
            up_run         = (alu_pwr_en && alu_iso_en) ? up_run + 1 : 0;
            prev2_iso      = prev_iso;
            prev_iso       = alu_iso_en;
            prev_pwr       = alu_pwr_en;
            prev_any_valid = (|req_valid) && !rst;
            prev_rst       = rst;
            if (rst) begin
                txn_active = 1'b0;
                ptr_m      = 0;
                idle_run   = 0;
                up_run     = 0;
            end
        end
    end

    // Caller is positioned just after a rising edge; valid is dropped after the accept edge.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, output int acc);
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_op[4*id +: 4]  = op;
        req_valid[id]      = 1'b1;
        acc = -1;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            @(negedge clk);
            if (req_ready[id]) acc = cyc;
        end
        if (acc < 0) check("accept_timeout", req_ready[id], 1'b1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int id, input logic [15:0] data, input int acc, input int lat);
        int got = -1;
        for (int k = 0; k < 300 && got < 0; k++) begin
            @(negedge clk);
            if (rsp_valid) got = cyc;
        end
        if (got < 0) begin
            check("rsp_timeout", rsp_valid, 1'b1);
        end else begin
            check("lit_latency", got - acc, lat);
            check("lit_rsp_data", rsp_data, data);
            check("lit_rsp_id", rsp_id, id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_count(input int n);
        for (int k = 0; k < 300 && rsp_log.size() < n; k++) @(negedge clk);
        check("rsp_count", rsp_log.size(), n);
    endtask

    int exp_rr[4] = '{0, 1, 0, 1};

    initial begin
        int acc, c0, gstart, rstart, t_iso;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold request: 4 power-up cycles then accept in the first READY cycle.
        c0 = cyc;
        issue(0, 16'd3, 16'd5, 4'd0, acc);
        check("cold_accept_delay", acc - c0, 5);
        wait_rsp(0, 16'd8, acc, 3);

        issue(0, 16'd300, 16'd7, 4'd8, acc);
        wait_rsp(0, 16'd2100, acc, 8);
        issue(0, 16'd100, 16'd0, 4'd9, acc);
        wait_rsp(0, 16'd0, acc, 12);
        issue(1, 16'd100, 16'd7, 4'd9, acc);
        wait_rsp(1, 16'd14, acc, 12);

        // Both requesters held valid; second op of requester 1 is undefined (returns 0).
        gstart = grant_log.size();
        rstart = rsp_log.size();
        fork
            begin
                int a0, a1;
                issue(0, 16'd1, 16'd2, 4'd0, a0);
                issue(0, 16'd10, 16'd3, 4'd1, a1);
            end
            begin
                int b0, b1;
                issue(1, 16'h00FF, 16'h0F0F, 4'd4, b0);
                issue(1, 16'd12, 16'd10, 4'd5, b1);
            end
        join
        wait_rsp_count(rstart + 4);
        check("rr_grant_count", grant_log.size() - gstart, 4);
        for (int i = 0; i < 4; i++) begin
            if (gstart + i < grant_log.size()) check("rr_grant_order", grant_log[gstart + i], exp_rr[i]);
            if (rstart + i < rsp_log.size())   check("rr_rsp_id_order", rsp_log[rstart + i], exp_rr[i]);
        end

        // Idle power-down: 16 idle READY cycles, one ISO_ON cycle, then OFF.
        t_iso = -1;
        for (int k = 0; k < 60 && t_iso < 0; k++) begin
            @(negedge clk);
            if (alu_pwr_en && alu_iso_en) t_iso = cyc;
        end
        if (t_iso < 0) check("idle_iso_seen", alu_iso_en, 1'b1);
        else           check("idle_iso_cycle", t_iso - last_rsp_cyc, IDLE_TIMEOUT + 1);
        @(negedge clk);
        check("idle_pwr_off", alu_pwr_en, 1'b0);
        check("idle_iso_kept", alu_iso_en, 1'b1);

        @(posedge clk); #1;
        c0 = cyc;
        issue(0, 16'h00F0, 16'h0FF0, 4'd2, acc);
        check("repower_accept_delay", acc - c0, 5);
        wait_rsp(0, 16'h00F0, acc, 3);

        // Reset during WAIT of a MUL; pointer is 1 before reset.
        issue(0, 16'd300, 16'd7, 4'd8, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_pwr_en", alu_pwr_en, 1'b0);
        check("midrst_iso_en", alu_iso_en, 1'b1);
        check("midrst_start", alu_start, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("midrst_no_rsp", rsp_valid, 1'b0);
        end

        @(posedge clk); #1;
        gstart = grant_log.size();
        rstart = rsp_log.size();
        fork
            begin
                int a0;
                issue(1, 16'hAAAA, 16'h5555, 4'd3, a0);
            end
            begin
                int b0;
                issue(0, 16'd9, 16'd4, 4'd1, b0);
            end
        join
        wait_rsp_count(rstart + 2);
        check("post_rst_grant_count", grant_log.size() - gstart, 2);
        if (grant_log.size() >= gstart + 2) begin
            check("post_rst_first_grant", grant_log[gstart], 0);
            check("post_rst_second_grant", grant_log[gstart + 1], 1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
